// File: rtl/pre_if_stage_if.sv
// Fetch handshake bundle between pre_if_stage, if_stage and the instruction cache.
// The master side is the pre-IF stage; the slave side is if_stage plus the cache.
interface pre_if_stage_if;
    logic        fs_allowin;
    logic        to_fs_valid;
    logic [70:0] preif_to_fs_bus;
    logic        inst_cache_valid;
    logic [31:0] inst_cache_addr;
    logic        inst_cache_addr_ok;

    modport master (
        input  fs_allowin,
        input  inst_cache_addr_ok,
        output to_fs_valid,
        output preif_to_fs_bus,
        output inst_cache_valid,
        output inst_cache_addr
    );

    modport slave (
        output fs_allowin,
        output inst_cache_addr_ok,
        input  to_fs_valid,
        input  preif_to_fs_bus,
        input  inst_cache_valid,
        input  inst_cache_addr
    );
endinterface

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues I-cache requests and applies flush/branch redirects.
// Define PFS_TLB_EXC_EN to tag TLB refill/invalid fetch exceptions (TLBL) on mapped addresses.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC     = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
    parameter logic [31:0] REFILL_ENTRY = 32'hbfc00200
) (
    input  logic                  clk,
    input  logic                  reset,
    pre_if_stage_if.master        fs,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    input  logic                  fs_ex,
    input  logic                  ex_is_refill,
    input  logic                  fs_eret_in,
    input  logic [31:0]           cp0_epc,
    input  logic                  fs_cancel_in,
    input  logic [31:0]           cancel_pc,
    input  logic                  tlb_refill,
    input  logic                  tlb_invalid
);

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        br_pending_r;
    logic [31:0] br_pc_r;

    logic        flush_s;
    logic [31:0] flush_target_s;
    logic        req_s;
    logic        accept_s;
    logic [38:0] exc_s;

    // Returns {tlb_refill, badvaddr, has_exc, exc_type}; AdEL outranks the TLB exceptions.
    function automatic logic [38:0] fetch_exc(input logic [31:0] pc,
                                              input logic        refill,
                                              input logic        invalid);
        logic [38:0] r;
        r = 39'd0;
        if (pc[1:0] != 2'b00) begin
            r = {1'b0, pc, 1'b1, 5'h04};
        end else begin
`ifdef PFS_TLB_EXC_EN
            if ((!pc[31] || (pc[31:30] == 2'b11)) && (refill || invalid)) begin
                r = {refill, pc, 1'b1, 5'h02};
            end else begin
                r = 39'd0;
            end
`else
            r = 39'd0;
`endif
        end
        return r;
    endfunction

`ifndef PFS_TLB_EXC_EN
    logic unused_tlb_s;
    assign unused_tlb_s = tlb_refill ^ tlb_invalid;
`endif

    // Request, accept and flush-target decode for the current cycle.
    always_comb begin
        flush_s        = fs_ex | fs_eret_in | fs_cancel_in;
        flush_target_s = 32'd0;
        if (fs_ex) begin
            flush_target_s = ex_is_refill ? REFILL_ENTRY : EX_ENTRY;
        end else if (fs_eret_in) begin
            flush_target_s = cp0_epc;
        end else if (fs_cancel_in) begin
            flush_target_s = cancel_pc;
        end else begin
            flush_target_s = 32'd0;
        end
        // Reset is folded in so an in-flight request drops in the reset cycle itself.
        req_s    = (state_r == S_RUN) & fs.fs_allowin & ~flush_s & ~reset;
        accept_s = req_s & fs.inst_cache_addr_ok;
`ifdef PFS_TLB_EXC_EN
        exc_s    = fetch_exc(pc_r, tlb_refill, tlb_invalid);
`else
        exc_s    = fetch_exc(pc_r, 1'b0, 1'b0);
`endif
    end

    // FSM, fetch PC and pending-branch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_BOOT;
            pc_r         <= RESET_PC;
            br_pending_r <= 1'b0;
            br_pc_r      <= 32'd0;
        end else begin
            case (state_r)
                S_BOOT:  state_r <= S_RUN;
                S_RUN:   state_r <= S_RUN;
                default: state_r <= S_BOOT;
            endcase
            if (flush_s) begin
                pc_r         <= flush_target_s;
                br_pending_r <= 1'b0;
            end else if (accept_s) begin
                br_pending_r <= 1'b0;
                if (br_taken) begin
                    pc_r <= br_target;
                end else if (br_pending_r) begin
                    pc_r <= br_pc_r;
                end else begin
                    pc_r <= pc_r + 32'd4;
                end
            end else if (br_taken) begin
                br_pending_r <= 1'b1;
                br_pc_r      <= br_target;
            end else begin
                br_pending_r <= br_pending_r;
            end
        end
    end

    assign fs.inst_cache_valid = req_s;
    assign fs.inst_cache_addr  = {pc_r[31:2], 2'b00};
    assign fs.to_fs_valid      = accept_s;
    assign fs.preif_to_fs_bus  = accept_s ? {exc_s, pc_r} : 71'd0;

endmodule

// File: tb/tb_pre_if_stage.sv
// Scoreboard bench for pre_if_stage: the driver queues each expected accepted bus word,
// a negedge monitor pops and compares whenever to_fs_valid is asserted.
module tb_pre_if_stage;
    logic        clk;
    logic        reset;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_ex;
    logic        ex_is_refill;
    logic        fs_eret_in;
    logic [31:0] cp0_epc;
    logic        fs_cancel_in;
    logic [31:0] cancel_pc;
    logic        tlb_refill;
    logic        tlb_invalid;

    pre_if_stage_if ifc ();

    pre_if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .fs           (ifc.master),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .fs_ex        (fs_ex),
        .ex_is_refill (ex_is_refill),
        .fs_eret_in   (fs_eret_in),
        .cp0_epc      (cp0_epc),
        .fs_cancel_in (fs_cancel_in),
        .cancel_pc    (cancel_pc),
        .tlb_refill   (tlb_refill),
        .tlb_invalid  (tlb_invalid)
    );

    int checks = 0;
    int errors = 0;
    logic [70:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic has, input logic [4:0] typ,
                        input logic [31:0] badv, input logic refill);
        exp_q.push_back({refill, badv, has, typ, pc});
    endtask

    task automatic push_ok(input logic [31:0] pc);
        push(pc, 1'b0, 5'h00, 32'd0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string name);
        #3;
        chk({name, "_icv"}, {70'd0, ifc.inst_cache_valid}, 71'd0);
        chk({name, "_tfv"}, {70'd0, ifc.to_fs_valid}, 71'd0);
    endtask

    // Monitor: every accepted entry must match the head of the expected queue.
    always @(negedge clk) begin
        if (ifc.to_fs_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept bus=%h addr=%h", ifc.preif_to_fs_bus, ifc.inst_cache_addr);
            end else begin
                logic [70:0] e;
                e = exp_q.pop_front();
                chk("bus", ifc.preif_to_fs_bus, e);
                chk("addr", {39'd0, ifc.inst_cache_addr}, {39'd0, e[31:2], 2'b00});
                chk("icv_on_accept", {70'd0, ifc.inst_cache_valid}, 71'd1);
            end
        end
    end

    initial begin
        reset = 1'b1; br_taken = 1'b0; br_target = 32'd0; fs_ex = 1'b0; ex_is_refill = 1'b0;
        fs_eret_in = 1'b0; cp0_epc = 32'd0; fs_cancel_in = 1'b0; cancel_pc = 32'd0;
        tlb_refill = 1'b0; tlb_invalid = 1'b0;
        ifc.fs_allowin = 1'b1; ifc.inst_cache_addr_ok = 1'b1;

        // Reset state
        cyc();
        idle_chk("reset");
        chk("reset_bus", ifc.preif_to_fs_bus, 71'd0);
        // 1: boot cycle idle, then sequential fetch
        cyc(); reset = 1'b0;
        idle_chk("boot");
        cyc(); push_ok(32'hbfc00000);
        cyc(); push_ok(32'hbfc00004);
        cyc(); push_ok(32'hbfc00008);
        cyc(); push_ok(32'hbfc0000c);
        // 2: three-cycle stall at bfc00010
        for (int i = 0; i < 3; i++) begin
            cyc(); ifc.inst_cache_addr_ok = 1'b0;
            #3;
            chk("stall_addr", {39'd0, ifc.inst_cache_addr}, {39'd0, 32'hbfc00010});
            chk("stall_tfv", {70'd0, ifc.to_fs_valid}, 71'd0);
        end
        cyc(); ifc.inst_cache_addr_ok = 1'b1; push_ok(32'hbfc00010);
        cyc(); push_ok(32'hbfc00014);
        // 3: branch arrives while stalled, taken after the stalled entry
        cyc(); ifc.inst_cache_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h80001000;
        cyc(); br_taken = 1'b0;
        #3;
        chk("br_stall_addr", {39'd0, ifc.inst_cache_addr}, {39'd0, 32'hbfc00018});
        cyc(); ifc.inst_cache_addr_ok = 1'b1; push_ok(32'hbfc00018);
        cyc(); push_ok(32'h80001000);
        cyc(); push_ok(32'h80001004);
        // 4: refill exception beats a same-cycle branch
        cyc(); fs_ex = 1'b1; ex_is_refill = 1'b1; br_taken = 1'b1; br_target = 32'h12345678;
        idle_chk("ex_flush");
        cyc(); fs_ex = 1'b0; ex_is_refill = 1'b0; br_taken = 1'b0; push_ok(32'hbfc00200);
        cyc(); push_ok(32'hbfc00204);
        // 5: eret to a misaligned epc raises AdEL
        cyc(); fs_eret_in = 1'b1; cp0_epc = 32'h80000002;
        idle_chk("eret_flush");
        cyc(); fs_eret_in = 1'b0; push(32'h80000002, 1'b1, 5'h04, 32'h80000002, 1'b0);
        cyc(); push(32'h80000006, 1'b1, 5'h04, 32'h80000006, 1'b0);
        // eret outranks cancel and branch
        cyc(); fs_eret_in = 1'b1; cp0_epc = 32'h80002000; fs_cancel_in = 1'b1;
        cancel_pc = 32'h90000000; br_taken = 1'b1; br_target = 32'h11111110;
        idle_chk("prio_flush");
        cyc(); fs_eret_in = 1'b0; fs_cancel_in = 1'b0; br_taken = 1'b0; push_ok(32'h80002000);
        cyc(); ifc.fs_allowin = 1'b0;
        idle_chk("no_allowin");
        // 6: TLB refill on a mapped address
        cyc(); fs_cancel_in = 1'b1; cancel_pc = 32'h00400000; ifc.fs_allowin = 1'b1;
        idle_chk("cancel_flush");
        cyc(); fs_cancel_in = 1'b0; tlb_refill = 1'b1;
`ifdef PFS_TLB_EXC_EN
        push(32'h00400000, 1'b1, 5'h02, 32'h00400000, 1'b1);
`else
        push_ok(32'h00400000);
`endif
        cyc(); tlb_refill = 1'b0; ifc.fs_allowin = 1'b0;
        // pc+4 wraps past the top of the address space
        cyc(); fs_cancel_in = 1'b1; cancel_pc = 32'hfffffffc; ifc.fs_allowin = 1'b1;
        cyc(); fs_cancel_in = 1'b0; push_ok(32'hfffffffc);
        cyc(); push_ok(32'h00000000);
        // Reset while requesting drops the request immediately
        cyc(); reset = 1'b1;
        idle_chk("mid_reset");
        chk("mid_reset_bus", ifc.preif_to_fs_bus, 71'd0);
        cyc(); reset = 1'b0;
        idle_chk("reboot");
        cyc(); push_ok(32'hbfc00000);
        cyc(); ifc.fs_allowin = 1'b0;
        cyc();
        cyc();
        chk("queue_drained", {39'd0, 32'(exp_q.size())}, 71'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
